// File: rtl/sobol_bitstream_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobol_bitstream_gen_pkg
//  Description : Shared constants for the Sobol-driven stochastic bitstream
//                generator: default width, FSM encoding, stream length.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobol_bitstream_gen_pkg;

    localparam int BITWIDTH_DEF = 8;
    localparam int STREAM_LEN   = 1 << BITWIDTH_DEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int streamLen(input int bw);
        return 1 << bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobol_bitstream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sobol_bitstream_gen_if
//  Description : Operand handshake, RNG link and bitstream outputs of the
//                stochastic bitstream generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sobol_bitstream_gen_if
    import sobol_bitstream_gen_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF
);
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iData;
    logic [BITWIDTH-1:0] iRand;
    logic                oRngEn;
    logic                oBit;
    logic                oBitValid;
    logic                oDone;
    logic [BITWIDTH-1:0] oOnesCnt;

    modport slave (
        input  iValid, iData, iRand,
        output oReady, oRngEn, oBit, oBitValid, oDone, oOnesCnt
    );

    modport master (
        output iValid, iData, iRand,
        input  oReady, oRngEn, oBit, oBitValid, oDone, oOnesCnt
    );
endinterface
`default_nettype wire

// File: rtl/sobol_bitstream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sobol_bitstream_gen
//  Description : Converts one binary operand into a 2^BITWIDTH-bit unary
//                stochastic stream by comparison against a Sobol sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobol_bitstream_gen
    import sobol_bitstream_gen_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF
) (
    input  wire                   iClk,
    input  wire                   iRst,
    sobol_bitstream_gen_if.slave  bus
);

    localparam logic [BITWIDTH-1:0] c_lenMax = BITWIDTH'(streamLen(BITWIDTH) - 1);

    logic [1:0]          r_state;
    logic [BITWIDTH-1:0] r_data;
    logic [BITWIDTH-1:0] r_lenCnt;
    logic [BITWIDTH-1:0] r_onesCnt;
    logic                w_run;
    logic                w_bit;

    assign w_run = (r_state == ST_RUN);
    assign w_bit = w_run && (bus.iRand < r_data);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_lenCnt  <= '0;
            r_onesCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.iValid) begin
                        r_data    <= bus.iData;
                        r_lenCnt  <= '0;
                        r_onesCnt <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Counter wraps to zero on the final bit; onesCnt tops out at 2^BITWIDTH-1.
                    r_lenCnt  <= r_lenCnt + 1'b1;
                    r_onesCnt <= r_onesCnt + {{(BITWIDTH-1){1'b0}}, w_bit};
                    if (r_lenCnt == c_lenMax) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oReady    = (r_state == ST_IDLE);
    assign bus.oRngEn    = w_run;
    assign bus.oBitValid = w_run;
    assign bus.oBit      = w_bit;
    assign bus.oDone     = (r_state == ST_DONE);
    assign bus.oOnesCnt  = r_onesCnt;

endmodule
`default_nettype wire

// File: doc/sobol_bitstream_gen.md
Name: sobol_bitstream_gen

Overview:
- Downstream consumer of the Sobol RNG.
- Accepts one binary operand per transaction over a valid/ready handshake. Emits a unary stochastic bitstream of exactly 2^BITWIDTH bits by comparing the operand against the incoming Sobol sequence.
- Drives the RNG enable so the RNG advances only while a stream is being produced.
- Reports the stream's ones-count at completion for self-check and downstream accumulation.

Parameters:
- BITWIDTH, 8, operand/RNG width; supported 2-10. Matches the `BITWIDTH of the RNG instance.

Ports:
- iClk  input  1  clock; all state on rising edge
- iRst  input  1  reset; asynchronous, active-high
- iValid  input  1  operand valid
- oReady  output  1  block can accept an operand (IDLE)
- iData  input  BITWIDTH  unsigned operand; probability = iData / 2^BITWIDTH
- iRand  input  BITWIDTH  Sobol sample from the RNG (registered RNG output)
- oRngEn  output  1  enable to the RNG iEn; advances the sequence
- oBit  output  1  stochastic bit
- oBitValid  output  1  oBit is a stream bit this cycle
- oDone  output  1  one-cycle pulse; stream complete
- oOnesCnt  output  BITWIDTH  number of 1s in the last completed stream

Behaviour:
- States: IDLE, RUN, DONE. Two-bit encoding from the shared package.
- Reset (async, any state, any time):
  - state=IDLE, dataReg=0, lenCnt=0, onesCnt=0.
  - Outputs: oReady=1, oRngEn=0, oBit=0, oBitValid=0, oDone=0, oOnesCnt=0.
  - Reset mid-RUN abandons the stream with no oDone. The RNG is reset by the same system reset, so RNG phase stays aligned.
- IDLE:
  - oReady=1.
  - On iValid&oReady at edge T: dataReg<=iData, lenCnt<=0, onesCnt<=0, state<=RUN. First stream bit appears in cycle T+1.
- RUN:
  - oReady=0. oRngEn=1, oBitValid=1, combinational from state.
  - oBit = (iRand < dataReg), unsigned, combinational.
  - Each edge: lenCnt<=lenCnt+1; onesCnt<=onesCnt+oBit.
  - When lenCnt==2^BITWIDTH-1: state<=DONE. The final bit is counted on that edge.
  - Exactly 2^BITWIDTH cycles in RUN.
- DONE (one cycle):
  - oDone=1, oRngEn=0, oBitValid=0, oReady=0.
  - oOnesCnt is the registered onesCnt. It holds its value until the next accepted operand, then clears with onesCnt.
  - state<=IDLE next edge.
- oBit=0 whenever state!=RUN.
- iValid in RUN/DONE is ignored. The producer must hold iValid/iData until oReady.
- Arithmetic:
  - lenCnt is BITWIDTH bits and wraps to 0 at the DONE transition.
  - onesCnt is BITWIDTH bits and never overflows: the max is 2^BITWIDTH-1 because iRand<dataReg is false for at least one sample.
- Invariant: the RNG is enabled only in whole periods from reset, so each stream sees a full permutation of 0..2^BITWIDTH-1. Therefore oOnesCnt==iData exactly.
- Back-to-back throughput: one stream per 2^BITWIDTH+2 cycles (RUN + DONE + IDLE accept).

Decomposition:
- Shared package/def:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_DONE=2
  - BITWIDTH default from sobolrng.def
  - STREAM_LEN = 1<<BITWIDTH
- No sub-module required. Comparator, length counter and ones counter are inline.
- Top-level pairing with the RNG, oRngEn->iEn and sobolSeq->iRand, lives in the integrating wrapper, not here.

Test Plan:
- BITWIDTH=8, iData=100 after reset -> oBitValid high 256 consecutive cycles, exactly 100 ones on oBit, oDone pulse 1 cycle, oOnesCnt=100.
- iData=0 -> 256 zero bits, oOnesCnt=0. iData=255 -> 255 ones, oOnesCnt=255.
- Back-to-back iData=64 then 192, iValid held high -> second accept one cycle after oDone. Counts 64 and 192; RNG enable count total 512.
- iValid toggled with changing iData during RUN -> ignored; oOnesCnt equals the originally accepted value; oReady low throughout RUN/DONE.
- Assert iRst at cycle 50 of RUN -> all outputs at reset values immediately (async), no oDone. After release, iData=37 gives oOnesCnt=37.
- BITWIDTH=2 sweep, iData 0..3 -> stream length 4, oOnesCnt==iData for all.
